// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP definitions.
//   IP_W, MAC_W, AGE_W : field widths of one cache entry
//   MAC_BCAST          : all-ones broadcast hardware address
//   MCAST_BIT          : group (I/G) bit of a MAC address, set for multicast
//   arp_entry_t        : one IP-to-MAC binding with its valid flag and age
//   is_group_mac()     : true for multicast or broadcast hardware addresses
package eth_pkg;

  localparam int IP_W      = 32;
  localparam int MAC_W     = 48;
  localparam int AGE_W     = 16;
  localparam int MCAST_BIT = 40;

  localparam logic [MAC_W-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic             valid;
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
    logic [AGE_W-1:0] age;
  } arp_entry_t;

  function automatic logic is_group_mac(input logic [MAC_W-1:0] mac);
    return mac[MCAST_BIT] || (mac == MAC_BCAST);
  endfunction

endpackage

// File: rtl/first_free_enc.sv
// Lowest-index priority encoder over a vector of free slots.
//   free  : one bit per slot, 1 = slot available
//   idx   : index of the lowest set bit (0 when none set)
//   found : at least one bit of free is set
module first_free_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  free,
  output logic [IW-1:0] idx,
  output logic          found
);

  // NOTE: defaults are assigned before the loop so every path drives both
  // outputs; without them this block would infer latches.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan from the top down so the lowest free slot is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arp_cache.sv
// Small fully associative IP-to-MAC cache fed by the ARP receive path and
// queried by the transmit path.
//   learn_valid/ip/mac : binding to learn (group senders and 0.0.0.0 ignored)
//   lookup_valid/ip    : resolve request; lookup_ready accepts it
//   rsp_valid/hit/mac  : response one cycle after an accepted lookup
//   age_tick           : ageing strobe; entries expire after MAX_AGE ticks
//   flush              : invalidate everything, reset the victim pointer
//   occupancy          : registered count of valid entries
module arp_cache
  import eth_pkg::*;
#(
  parameter int               ENTRIES = 8,
  parameter logic [AGE_W-1:0] MAX_AGE = 16'd60000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       learn_valid,
  input  logic [IP_W-1:0]            learn_ip,
  input  logic [MAC_W-1:0]           learn_mac,
  input  logic                       lookup_valid,
  input  logic [IP_W-1:0]            lookup_ip,
  output logic                       lookup_ready,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic [MAC_W-1:0]           rsp_mac,
  input  logic                       age_tick,
  input  logic                       flush,
  output logic [$clog2(ENTRIES):0]   occupancy
);

  localparam int IW    = $clog2(ENTRIES);
  localparam int OCC_W = IW + 1;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [AGE_W-1:0]   age_q [ENTRIES];
  logic [AGE_W-1:0]   age_d [ENTRIES];
  logic [IP_W-1:0]    ip_q  [ENTRIES];
  logic [MAC_W-1:0]   mac_q [ENTRIES];
  logic [IW-1:0]      victim_q, victim_d;
  logic [OCC_W-1:0]   occ_d;

  // Lookup side: the table is read from registered state, so a learn in the
  // same cycle is not yet visible (read before write).
  arp_entry_t lk_entry;
  logic       accept;

  assign lookup_ready = rst_n && !flush;
  assign accept       = lookup_valid && lookup_ready;

  always_comb begin
    lk_entry = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (ip_q[i] == lookup_ip)) begin
        lk_entry.valid = 1'b1;
        lk_entry.ip    = ip_q[i];
        lk_entry.mac   = mac_q[i];
        lk_entry.age   = age_q[i];
      end
    end
  end

  // Learn side: refresh an existing binding first, then the lowest free slot,
  // and only evict through the round-robin victim pointer when full.
  logic          learn_ok, ln_hit, free_found, use_victim;
  logic [IW-1:0] ln_idx, free_idx, wr_idx;

  assign learn_ok = learn_valid && (learn_ip != '0) && !is_group_mac(learn_mac);

  always_comb begin
    ln_hit = 1'b0;
    ln_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (ip_q[i] == learn_ip)) begin
        ln_hit = 1'b1;
        ln_idx = IW'(i);
      end
    end
  end

  first_free_enc #(.N(ENTRIES), .IW(IW)) u_first_free (
    .free  (~valid_q),
    .idx   (free_idx),
    .found (free_found)
  );

  assign use_victim = learn_ok && !ln_hit && !free_found;
  assign wr_idx     = ln_hit ? ln_idx : (free_found ? free_idx : victim_q);

  // Priority, lowest to highest: ageing, learn, flush.
  always_comb begin
    valid_d  = valid_q;
    age_d    = age_q;
    victim_d = victim_q;
    if (age_tick) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i]) begin
          if (age_q[i] != '1) age_d[i] = age_q[i] + AGE_W'(1);
          if (age_d[i] >= MAX_AGE) valid_d[i] = 1'b0;
        end
      end
    end
    if (learn_ok) begin
      valid_d[wr_idx] = 1'b1;
      age_d[wr_idx]   = '0;
      // ENTRIES is a power of two, so the increment wraps by itself.
      if (use_victim) victim_d = victim_q + IW'(1);
    end
    if (flush) begin
      valid_d  = '0;
      victim_d = '0;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++) occ_d = occ_d + OCC_W'(valid_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      victim_q  <= '0;
      occupancy <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_mac   <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      victim_q  <= victim_d;
      occupancy <= occ_d;
      age_q     <= age_d;
      rsp_valid <= accept;
      rsp_hit   <= accept && lk_entry.valid;
      rsp_mac   <= (accept && lk_entry.valid) ? lk_entry.mac : '0;
    end
  end

  // NOTE: the address/MAC storage deliberately has no reset; it is only ever
  // observed through a set valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (learn_ok && !flush) begin
      ip_q[wr_idx]  <= learn_ip;
      mac_q[wr_idx] <= learn_mac;
    end
  end

endmodule

// File: tb/tb_arp_cache.sv
// Directed bench for arp_cache (ENTRIES=8, MAX_AGE=3). Lookups push their
// expected response into a scoreboard queue; a monitor on the falling edge
// pops and compares every response the DUT presents.
module tb_arp_cache;

  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        learn_valid, lookup_valid, age_tick, flush;
  logic [31:0] learn_ip, lookup_ip;
  logic [47:0] learn_mac;
  logic        lookup_ready, rsp_valid, rsp_hit;
  logic [47:0] rsp_mac;
  logic [3:0]  occupancy;

  typedef struct {
    logic        hit;
    logic [47:0] mac;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arp_cache #(.ENTRIES(ENTRIES), .MAX_AGE(16'd3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .learn_valid  (learn_valid),
    .learn_ip     (learn_ip),
    .learn_mac    (learn_mac),
    .lookup_valid (lookup_valid),
    .lookup_ip    (lookup_ip),
    .lookup_ready (lookup_ready),
    .rsp_valid    (rsp_valid),
    .rsp_hit      (rsp_hit),
    .rsp_mac      (rsp_mac),
    .age_tick     (age_tick),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
        check("rsp_mac", {16'd0, rsp_mac}, {16'd0, e.mac});
      end
    end else begin
      check("idle_rsp_zero", {15'd0, rsp_hit, rsp_mac}, 64'd0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
    learn_valid = 1'b1;
    learn_ip    = ip;
    learn_mac   = mac;
    cycle();
    learn_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] ip, input logic hit, input logic [47:0] mac);
    exp_t e;
    e.hit = hit;
    e.mac = mac;
    lookup_valid = 1'b1;
    lookup_ip    = ip;
    sb.push_back(e);
    cycle();
    lookup_valid = 1'b0;
  endtask

  task automatic tick();
    age_tick = 1'b1;
    cycle();
    age_tick = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    learn_valid = 1'b0; lookup_valid = 1'b0; age_tick = 1'b0; flush = 1'b0;
    learn_ip = '0; lookup_ip = '0; learn_mac = '0;
    repeat (3) cycle();
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ready_low", 64'(lookup_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(lookup_ready), 64'd1);
    cycle();

    // Empty table miss; ignored learns of 0.0.0.0 and a multicast sender.
    lookup(32'h0A00_0009, 1'b0, 48'h0);
    learn(32'h0000_0000, 48'hAABB_CCDD_EE01);
    learn(32'h0A00_0005, 48'h0100_5E00_0001);
    learn(32'h0A00_0006, 48'hFFFF_FFFF_FFFF);
    cycle();
    check("occ_ignored_learns", 64'(occupancy), 64'd0);

    // Basic learn then lookup.
    learn(32'h0A00_0001, 48'hAABB_CCDD_EE01);
    lookup(32'h0A00_0001, 1'b1, 48'hAABB_CCDD_EE01);
    cycle();
    check("occ_one", 64'(occupancy), 64'd1);

    // Relearn with a new MAC while looking up: old MAC returned this cycle.
    learn_valid = 1'b1; learn_ip = 32'h0A00_0001; learn_mac = 48'hAABB_CCDD_EE02;
    lookup(32'h0A00_0001, 1'b1, 48'hAABB_CCDD_EE01);
    learn_valid = 1'b0;
    lookup(32'h0A00_0001, 1'b1, 48'hAABB_CCDD_EE02);
    cycle();
    check("occ_relearn", 64'(occupancy), 64'd1);

    // Ageing: three ticks expire the entry.
    repeat (3) tick();
    lookup(32'h0A00_0001, 1'b0, 48'h0);
    cycle();
    check("occ_aged_out", 64'(occupancy), 64'd0);

    // Relearn on the third tick keeps the entry alive.
    learn(32'h0A00_0002, 48'h0211_2233_4455);
    tick();
    tick();
    age_tick = 1'b1;
    learn(32'h0A00_0002, 48'h0211_2233_4466);
    age_tick = 1'b0;
    lookup(32'h0A00_0002, 1'b1, 48'h0211_2233_4466);
    cycle();
    check("occ_refreshed", 64'(occupancy), 64'd1);
    do_flush();

    // Fill 8 slots, the 9th evicts slot 0.
    for (int k = 1; k <= 9; k++) learn(32'h0A00_0100 + 32'(k), 48'h0200_0000_0000 + 48'(k));
    cycle();
    check("occ_full", 64'(occupancy), 64'd8);
    lookup(32'h0A00_0101, 1'b0, 48'h0);
    lookup(32'h0A00_0109, 1'b1, 48'h0200_0000_0009);
    lookup(32'h0A00_0102, 1'b1, 48'h0200_0000_0002);

    // Learns 10..16 evict slots 1..7, pointer wraps, 17 evicts slot 0 (ip 9).
    for (int k = 10; k <= 17; k++) learn(32'h0A00_0100 + 32'(k), 48'h0200_0000_0000 + 48'(k));
    lookup(32'h0A00_0109, 1'b0, 48'h0);
    lookup(32'h0A00_010A, 1'b1, 48'h0200_0000_000A);
    lookup(32'h0A00_0110, 1'b1, 48'h0200_0000_0010);
    lookup(32'h0A00_0111, 1'b1, 48'h0200_0000_0011);
    cycle();
    check("occ_after_wrap", 64'(occupancy), 64'd8);

    // Flush overrides a simultaneous learn and refuses a lookup.
    do_flush();
    for (int k = 1; k <= 4; k++) learn(32'h0A00_0200 + 32'(k), 48'h0400_0000_0000 + 48'(k));
    cycle();
    check("occ_four", 64'(occupancy), 64'd4);
    flush = 1'b1;
    learn_valid = 1'b1; learn_ip = 32'h0A00_02FF; learn_mac = 48'h0400_0000_00FF;
    lookup_valid = 1'b1; lookup_ip = 32'h0A00_0201;
    #1;
    check("ready_during_flush", 64'(lookup_ready), 64'd0);
    cycle();
    flush = 1'b0; learn_valid = 1'b0; lookup_valid = 1'b0;
    cycle();
    check("occ_after_flush", 64'(occupancy), 64'd0);
    for (int k = 1; k <= 4; k++) lookup(32'h0A00_0200 + 32'(k), 1'b0, 48'h0);
    lookup(32'h0A00_02FF, 1'b0, 48'h0);
    cycle();

    // Reset right after a lookup is accepted drops its response.
    learn(32'h0A00_0301, 48'h0600_0000_0001);
    lookup_valid = 1'b1; lookup_ip = 32'h0A00_0301;
    cycle();
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    #1;
    check("rsp_dropped_in_rst", 64'(rsp_valid), 64'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    check("occ_after_rst", 64'(occupancy), 64'd0);
    lookup(32'h0A00_0301, 1'b0, 48'h0);

    repeat (3) cycle();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
